// File: rtl/adc_cap_seq_if.sv
// Bus bundle between the capture/readback sequencer and its environment:
// register-file requests, ADC input, sample memory port and frame buffer.
interface adc_cap_seq_if #(
   parameter int MEM_AW = 15,
   parameter int DW     = 9,
   parameter int FRAME  = 96
);
   logic                   write_pls;
   logic                   read_pls;
   logic [3:0]             cfg_mdio_rd_cnt;
   logic                   mdio_read;
   logic                   adc_vld;
   logic [DW-1:0]          adc_data;
   logic                   mem_we;
   logic [MEM_AW-1:0]      mem_waddr;
   logic [DW-1:0]          mem_wdata;
   logic                   mem_re;
   logic [MEM_AW-1:0]      mem_raddr;
   logic [DW-1:0]          mem_rdata;
   logic [DW*FRAME-1:0]    mdio_dout;
   logic                   mdio_data_vld;
   logic                   write_done;
   logic                   read_done;
   logic                   mdio_read_done;
   logic                   busy;

   // Sequencer side
   modport master (
      input  write_pls, read_pls, cfg_mdio_rd_cnt, mdio_read, adc_vld, adc_data, mem_rdata,
      output mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr, mdio_dout, mdio_data_vld,
             write_done, read_done, mdio_read_done, busy
   );

   // Register file / memory / ADC side
   modport slave (
      output write_pls, read_pls, cfg_mdio_rd_cnt, mdio_read, adc_vld, adc_data, mem_rdata,
      input  mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr, mdio_dout, mdio_data_vld,
             write_done, read_done, mdio_read_done, busy
   );
endinterface

// File: rtl/adc_cap_seq.sv
// Capture/readback sequencer: fills sample memory from the ADC on a write
// request, and streams memory back one frame at a time into the frame buffer
// on a read request, handing each frame to the host before fetching the next.
module adc_cap_seq #(
   parameter int MEM_AW = 15,
   parameter int DW     = 9,
   parameter int FRAME  = 96
) (
   input  logic          clk,
   input  logic          rstn,
   adc_cap_seq_if.master bus
);
   typedef enum logic [1:0] {IDLE, CAPTURE, FETCH, WAIT_HOST} state_t;

   localparam logic [6:0] LAST_IDX = 7'(FRAME - 1);

   state_t                   state_q, state_d;
   logic [MEM_AW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [MEM_AW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [6:0]               idx_q, idx_d;
   logic [6:0]               slot_q;
   logic                     drain_q, drain_d;
   logic                     rd_pend_q;
   logic [4:0]               frames_left_q, frames_left_d;
   logic                     write_done_q, write_done_d;
   logic                     read_done_q, read_done_d;
   logic                     mrd_done_q, mrd_done_d;
   logic                     vld_q, vld_d;
   logic                     mem_we, mem_re;
   logic [FRAME-1:0][DW-1:0] buf_q;

   // State and control register update
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q       <= IDLE;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         idx_q         <= '0;
         drain_q       <= 1'b0;
         frames_left_q <= '0;
         write_done_q  <= 1'b0;
         read_done_q   <= 1'b0;
         mrd_done_q    <= 1'b0;
         vld_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         idx_q         <= idx_d;
         drain_q       <= drain_d;
         frames_left_q <= frames_left_d;
         write_done_q  <= write_done_d;
         read_done_q   <= read_done_d;
         mrd_done_q    <= mrd_done_d;
         vld_q         <= vld_d;
      end
   end

   // Next-state, pointer/counter updates and memory strobes
   always_comb begin
      state_d       = state_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      idx_d         = idx_q;
      drain_d       = drain_q;
      frames_left_d = frames_left_q;
      write_done_d  = write_done_q;
      read_done_d   = read_done_q;
      mrd_done_d    = mrd_done_q;
      vld_d         = 1'b0;
      mem_we        = 1'b0;
      mem_re        = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.write_pls) begin
               state_d      = CAPTURE;
               wr_ptr_d     = '0;
               write_done_d = 1'b0;
            end else if (bus.read_pls) begin
               state_d       = FETCH;
               rd_ptr_d      = '0;
               idx_d         = '0;
               drain_d       = 1'b0;
               frames_left_d = (bus.cfg_mdio_rd_cnt == 4'd0) ? 5'd16 : {1'b0, bus.cfg_mdio_rd_cnt};
               read_done_d   = 1'b0;
               mrd_done_d    = 1'b0;
            end
         end
         CAPTURE: begin
            if (bus.adc_vld) begin
               mem_we   = 1'b1;
               wr_ptr_d = wr_ptr_q + 1'b1;
               if (wr_ptr_q == '1) begin
                  write_done_d = 1'b1;
                  state_d      = IDLE;
               end
            end
         end
         FETCH: begin
            // drain_q marks the extra cycle in which the last read's data
            // lands in the buffer; the frame is announced after it.
            if (!drain_q) begin
               mem_re   = 1'b1;
               rd_ptr_d = rd_ptr_q + 1'b1;
               if (idx_q == LAST_IDX) drain_d = 1'b1;
               else                   idx_d   = idx_q + 7'd1;
            end else begin
               state_d       = WAIT_HOST;
               vld_d         = 1'b1;
               frames_left_d = frames_left_q - 5'd1;
               if (frames_left_q == 5'd1) mrd_done_d = 1'b1;
            end
         end
         WAIT_HOST: begin
            if (bus.mdio_read) begin
               if (frames_left_q != 5'd0) begin
                  state_d = FETCH;
                  idx_d   = '0;
                  drain_d = 1'b0;
               end else begin
                  state_d     = IDLE;
                  read_done_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Read-data return tracking: slot k is written the cycle after read k
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rd_pend_q <= 1'b0;
         slot_q    <= '0;
      end else begin
         rd_pend_q <= mem_re;
         slot_q    <= idx_q;
      end
   end

   // Frame buffer: holds contents until overwritten by a later fetch
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) buf_q <= '0;
      else if (rd_pend_q) buf_q[slot_q] <= bus.mem_rdata;
   end

   assign bus.mem_we         = mem_we;
   assign bus.mem_waddr      = wr_ptr_q;
   assign bus.mem_wdata      = mem_we ? bus.adc_data : '0;
   assign bus.mem_re         = mem_re;
   assign bus.mem_raddr      = rd_ptr_q;
   assign bus.mdio_dout      = buf_q;
   assign bus.mdio_data_vld  = vld_q;
   assign bus.write_done     = write_done_q;
   assign bus.read_done      = read_done_q;
   assign bus.mdio_read_done = mrd_done_q;
   assign bus.busy           = (state_q != IDLE);
endmodule

// File: tb/tb_adc_cap_seq.sv
// Bench for adc_cap_seq: captures into a memory model, reads sessions back
// and checks every memory access and every delivered frame against a
// reference image of what was captured.
module tb_adc_cap_seq;
   localparam int MEM_AW = 8;
   localparam int DW     = 9;
   localparam int FRAME  = 96;
   localparam int DEPTH  = 1 << MEM_AW;

   logic clk = 1'b0;
   logic rstn;

   adc_cap_seq_if #(.MEM_AW(MEM_AW), .DW(DW), .FRAME(FRAME)) bus ();

   adc_cap_seq #(.MEM_AW(MEM_AW), .DW(DW), .FRAME(FRAME)) dut (
      .clk (clk),
      .rstn(rstn),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   logic [DW-1:0]       mem     [DEPTH];
   logic [DW-1:0]       ref_mem [DEPTH];
   logic [31:0]         wq      [$];   // {addr, data} expected writes
   logic [MEM_AW-1:0]   rq      [$];   // expected read addresses
   logic [DW*FRAME-1:0] fq      [$];   // expected frame images
   bit                  dq      [$];   // expected mdio_read_done per frame
   bit                  exp_wd;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Memory model: synchronous write, one-cycle read latency
   always @(posedge clk) begin
      if (bus.mem_we) mem[bus.mem_waddr] <= bus.mem_wdata;
      if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_raddr];
   end

   // Monitor: memory writes
   always @(negedge clk) begin
      if (rstn && bus.mem_we) begin
         if (wq.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_we: addr %0h data %0h at %0t", bus.mem_waddr, bus.mem_wdata, $time);
         end else begin
            logic [31:0] e;
            e = wq.pop_front();
            chk("we_addr", 32'(bus.mem_waddr), e[31:16]);
            chk("we_data", 32'(bus.mem_wdata), e[15:0]);
         end
      end
   end

   // Monitor: memory reads
   always @(negedge clk) begin
      if (rstn && bus.mem_re) begin
         if (rq.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_re: addr %0h at %0t", bus.mem_raddr, $time);
         end else begin
            chk("re_addr", 32'(bus.mem_raddr), 32'(rq.pop_front()));
         end
      end
   end

   // Monitor: delivered frames
   always @(negedge clk) begin
      if (rstn && bus.mdio_data_vld) begin
         if (fq.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_vld: mdio_data_vld with no frame expected at %0t", $time);
         end else begin
            logic [DW*FRAME-1:0] ef;
            logic [DW*FRAME-1:0] af;
            bit ed;
            ef = fq.pop_front();
            ed = dq.pop_front();
            af = bus.mdio_dout;
            n_chk++;
            if (af !== ef) begin
               n_fail++;
               for (int i = 0; i < FRAME; i++) begin
                  if (af[DW*i +: DW] !== ef[DW*i +: DW]) begin
                     $display("FAIL frame_data: slot %0d got %0h, expected %0h at %0t",
                              i, af[DW*i +: DW], ef[DW*i +: DW], $time);
                     break;
                  end
               end
            end
            chk("frame_read_done", 32'(bus.mdio_read_done), 32'(ed));
         end
      end
   end

   task automatic check_reset_outputs();
      chk("rst_mem_we", 32'(bus.mem_we), 0);
      chk("rst_mem_re", 32'(bus.mem_re), 0);
      chk("rst_vld", 32'(bus.mdio_data_vld), 0);
      chk("rst_write_done", 32'(bus.write_done), 0);
      chk("rst_read_done", 32'(bus.read_done), 0);
      chk("rst_mrd_done", 32'(bus.mdio_read_done), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_dout_nonzero", 32'(|bus.mdio_dout), 0);
      chk("rst_waddr", 32'(bus.mem_waddr), 0);
      chk("rst_raddr", 32'(bus.mem_raddr), 0);
      chk("rst_wdata", 32'(bus.mem_wdata), 0);
   endtask

   // Capture 2^MEM_AW samples; ramp mode writes addr as data every cycle
   task automatic do_capture(input bit ramp, input bit with_read);
      int addr = 0;
      int cyc  = 0;
      @(posedge clk); #1;
      bus.write_pls       = 1'b1;
      bus.read_pls        = with_read;
      bus.cfg_mdio_rd_cnt = 4'($urandom);
      @(posedge clk); #1;
      bus.write_pls = 1'b0;
      bus.read_pls  = 1'b0;
      exp_wd = 1'b0;
      chk("cap_busy", 32'(bus.busy), 1);
      chk("cap_write_done_clr", 32'(bus.write_done), 0);
      while (addr < DEPTH && cyc < 4000) begin
         logic          v;
         logic [DW-1:0] d;
         v = ramp ? 1'b1 : ($urandom_range(0, 3) != 0);
         d = ramp ? DW'(addr) : DW'($urandom);
         if (v) begin
            wq.push_back({16'(addr), 16'(d)});
            ref_mem[addr] = d;
            addr++;
         end
         bus.adc_vld  = v;
         bus.adc_data = d;
         bus.read_pls = (cyc == 20);   // must be ignored while capturing
         @(posedge clk); #1;
         cyc++;
      end
      bus.adc_vld  = 1'b0;
      bus.read_pls = 1'b0;
      chk("cap_complete", 32'(addr), 32'(DEPTH));
      chk("cap_write_done", 32'(bus.write_done), 1);
      chk("cap_busy_end", 32'(bus.busy), 0);
      exp_wd = 1'b1;
      // extra sample after completion must not be written
      bus.adc_vld  = 1'b1;
      bus.adc_data = DW'($urandom);
      @(posedge clk); #1;
      bus.adc_vld = 1'b0;
   endtask

   // Read session of cfg frames (0 = 16) with random host response delays
   task automatic do_read(input logic [3:0] cfg, input bit inject);
      int n = (cfg == 4'd0) ? 16 : int'(cfg);
      int k;
      for (int f = 0; f < n; f++) begin
         logic [DW*FRAME-1:0] ef;
         for (int i = 0; i < FRAME; i++) begin
            int a = (f * FRAME + i) % DEPTH;
            rq.push_back(MEM_AW'(a));
            ef[DW*i +: DW] = ref_mem[a];
         end
         fq.push_back(ef);
         dq.push_back(f == n - 1);
      end
      @(posedge clk); #1;
      bus.read_pls        = 1'b1;
      bus.cfg_mdio_rd_cnt = cfg;
      @(posedge clk); #1;
      bus.read_pls = 1'b0;
      chk("rd_busy", 32'(bus.busy), 1);
      chk("rd_read_done_clr", 32'(bus.read_done), 0);
      chk("rd_mrd_done_clr", 32'(bus.mdio_read_done), 0);
      chk("rd_write_done_kept", 32'(bus.write_done), 32'(exp_wd));
      k = 1;
      for (int f = 0; f < n; f++) begin
         int dly;
         while (!bus.mdio_data_vld && k < 200) begin
            bus.mdio_read = (inject && f == 1 && k == 10);   // ignored during FETCH
            @(posedge clk); #1;
            k++;
         end
         bus.mdio_read = 1'b0;
         chk("frame_latency", 32'(k), 98);
         if (!bus.mdio_data_vld) begin
            rq.delete(); fq.delete(); dq.delete();
            return;
         end
         dly = $urandom_range(0, 3);
         if (dly > 0) begin
            repeat (dly) begin @(posedge clk); #1; end
            chk("vld_is_pulse", 32'(bus.mdio_data_vld), 0);
         end
         bus.mdio_read = 1'b1;
         @(posedge clk); #1;
         bus.mdio_read = 1'b0;
         k = 1;
      end
      chk("sess_read_done", 32'(bus.read_done), 1);
      chk("sess_busy", 32'(bus.busy), 0);
      chk("sess_mrd_done", 32'(bus.mdio_read_done), 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn                = 1'b0;
      bus.write_pls       = 1'b0;
      bus.read_pls        = 1'b0;
      bus.cfg_mdio_rd_cnt = '0;
      bus.mdio_read       = 1'b0;
      bus.adc_vld         = 1'b0;
      bus.adc_data        = '0;
      bus.mem_rdata       = '0;
      exp_wd              = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         mem[i]     = '0;
         ref_mem[i] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs();
      rstn = 1'b1;

      do_capture(1'b1, 1'b1);           // ramp data, simultaneous read_pls dropped
      do_read(4'd1, 1'b0);              // single frame
      do_read(4'd0, 1'b1);              // 16 frames, address wrap, ignored mdio_read
      do_capture(1'b0, 1'b0);           // random data with gaps
      for (int s = 0; s < 3; s++) do_read(4'($urandom_range(1, 4)), 1'b0);

      // Abort mid-FETCH with an asynchronous reset
      for (int i = 0; i < 3 * FRAME; i++) rq.push_back(MEM_AW'(i % DEPTH));
      @(posedge clk); #1;
      bus.read_pls        = 1'b1;
      bus.cfg_mdio_rd_cnt = 4'd3;
      @(posedge clk); #1;
      bus.read_pls = 1'b0;
      repeat (30) begin @(posedge clk); #1; end
      chk("pre_rst_in_fetch", 32'(bus.mem_re), 1);
      rstn = 1'b0;
      #1;
      check_reset_outputs();
      rq.delete();
      exp_wd = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;

      do_capture(1'b0, 1'b0);
      do_read(4'd2, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      chk("wq_drained", 32'(wq.size()), 0);
      chk("rq_drained", 32'(rq.size()), 0);
      chk("fq_drained", 32'(fq.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
